ones_comp_accumulator: RTL and testbench

Streaming, parametrised one's-complement accumulator with end-around carry, generalising the fixed 4-bit two-operand one's-complement adder to WIDTH-bit words and frames of arbitrary length. It accepts one word per clock over a valid/ready handshake and folds each carry back into bit 0. It presents the frame sum and its complement (Internet-style checksum) over an output handshake. It sits between packet/word sources and checksum insertion/verification logic.

---
 rtl/ones_comp_accumulator_if.sv | 28 ++
 rtl/ones_comp_accumulator.sv | 86 ++++++++
 tb/tb_ones_comp_accumulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ones_comp_accumulator_if.sv
// Handshake bundle for the one's-complement accumulator: word input stream,
// result output stream and frame control.
interface ones_comp_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] checksum;
  logic [CNT_W-1:0] word_count;
  logic             busy;

  modport master (
    output clear, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, sum, checksum, word_count, busy
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, sum, checksum, word_count, busy
  );
endinterface

// File: rtl/ones_comp_accumulator.sv
// Streaming one's-complement accumulator with end-around carry; presents the
// frame sum, its complement and the accepted-word count over a handshake.
module ones_comp_accumulator #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int NORM_ZERO = 0
) (
  input  logic clk,
  input  logic rst,
  ones_comp_accumulator_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for the first word of a frame, acc cleared
  // ACCUM | frame in progress, more words expected
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   t_sum;
  logic [WIDTH-1:0] folded;
  logic [WIDTH-1:0] sum_out;

  // Folding the carry into bit 0 cannot carry again, so one cycle suffices.
  assign t_sum  = {1'b0, acc_q} + {1'b0, bus.in_data};
  assign folded = t_sum[WIDTH-1:0] + WIDTH'(t_sum[WIDTH]);
  assign accept = bus.in_valid && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = folded;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Negative zero may be reported as +0; the internal accumulator is untouched.
  assign sum_out        = ((NORM_ZERO != 0) && (&acc_q)) ? '0 : acc_q;
  assign bus.sum        = sum_out;
  assign bus.checksum   = ~sum_out;
  assign bus.word_count = cnt_q;
  assign bus.in_ready   = (state_q != DONE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_ones_comp_accumulator.sv
// Directed bench: 4-bit pair (raw / normalised zero) and 16-bit pair
// (8-bit / 2-bit word counter) driven from shared stimulus.
module tb_ones_comp_accumulator;
  logic clk;
  logic rst;

  logic       v4, l4, or4, clr4;
  logic [3:0] d4;
  logic        v16, l16, or16, clr16;
  logic [15:0] d16;

  int checks = 0;
  int errors = 0;

  ones_comp_accumulator_if #(.WIDTH(4),  .CNT_W(8)) if_a  ();
  ones_comp_accumulator_if #(.WIDTH(4),  .CNT_W(8)) if_an ();
  ones_comp_accumulator_if #(.WIDTH(16), .CNT_W(8)) if_b  ();
  ones_comp_accumulator_if #(.WIDTH(16), .CNT_W(2)) if_bc ();

  assign if_a.in_valid  = v4;   assign if_an.in_valid  = v4;
  assign if_a.in_data   = d4;   assign if_an.in_data   = d4;
  assign if_a.in_last   = l4;   assign if_an.in_last   = l4;
  assign if_a.out_ready = or4;  assign if_an.out_ready = or4;
  assign if_a.clear     = clr4; assign if_an.clear     = clr4;

  assign if_b.in_valid  = v16;   assign if_bc.in_valid  = v16;
  assign if_b.in_data   = d16;   assign if_bc.in_data   = d16;
  assign if_b.in_last   = l16;   assign if_bc.in_last   = l16;
  assign if_b.out_ready = or16;  assign if_bc.out_ready = or16;
  assign if_b.clear     = clr16; assign if_bc.clear     = clr16;

  ones_comp_accumulator #(.WIDTH(4), .CNT_W(8), .NORM_ZERO(0))
    u_a  (.clk(clk), .rst(rst), .bus(if_a));
  ones_comp_accumulator #(.WIDTH(4), .CNT_W(8), .NORM_ZERO(1))
    u_an (.clk(clk), .rst(rst), .bus(if_an));
  ones_comp_accumulator #(.WIDTH(16), .CNT_W(8), .NORM_ZERO(0))
    u_b  (.clk(clk), .rst(rst), .bus(if_b));
  ones_comp_accumulator #(.WIDTH(16), .CNT_W(2), .NORM_ZERO(0))
    u_bc (.clk(clk), .rst(rst), .bus(if_bc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_values();
    chk("rst_a_ovalid", 32'(if_a.out_valid), 32'h0);
    chk("rst_a_iready", 32'(if_a.in_ready), 32'h1);
    chk("rst_a_busy",   32'(if_a.busy), 32'h0);
    chk("rst_a_sum",    32'(if_a.sum), 32'h0);
    chk("rst_a_cks",    32'(if_a.checksum), 32'hF);
    chk("rst_a_wc",     32'(if_a.word_count), 32'h0);
    chk("rst_b_ovalid", 32'(if_b.out_valid), 32'h0);
    chk("rst_b_iready", 32'(if_b.in_ready), 32'h1);
    chk("rst_b_busy",   32'(if_b.busy), 32'h0);
    chk("rst_b_sum",    32'(if_b.sum), 32'h0);
    chk("rst_b_cks",    32'(if_b.checksum), 32'hFFFF);
    chk("rst_b_wc",     32'(if_b.word_count), 32'h0);
  endtask

  logic [15:0] ip_words [9];

  initial begin
    ip_words[0] = 16'h4500; ip_words[1] = 16'h0073; ip_words[2] = 16'h0000;
    ip_words[3] = 16'h4000; ip_words[4] = 16'h4011; ip_words[5] = 16'hC0A8;
    ip_words[6] = 16'h0001; ip_words[7] = 16'hC0A8; ip_words[8] = 16'h00C7;

    rst = 1'b1;
    v4 = 0; l4 = 0; or4 = 1; clr4 = 0; d4 = '0;
    v16 = 0; l16 = 0; or16 = 1; clr16 = 0; d16 = '0;
    #1;
    chk_rst_values();
    #11 rst = 1'b0;

    // ---- 4-bit: {5, 3 last}
    v4 = 1; d4 = 4'h5; l4 = 0;
    step();
    chk("f53_busy", 32'(if_a.busy), 32'h1);
    chk("f53_ov_early", 32'(if_a.out_valid), 32'h0);
    d4 = 4'h3; l4 = 1;
    step();
    chk("f53_ovalid", 32'(if_a.out_valid), 32'h1);
    chk("f53_sum", 32'(if_a.sum), 32'h8);
    chk("f53_cks", 32'(if_a.checksum), 32'h7);
    chk("f53_wc", 32'(if_a.word_count), 32'h2);
    chk("f53_iready", 32'(if_a.in_ready), 32'h0);
    v4 = 0;
    step();
    chk("f53_ov_drop", 32'(if_a.out_valid), 32'h0);
    chk("f53_wc_clr", 32'(if_a.word_count), 32'h0);

    // ---- end-around carry {A, 9 last}
    v4 = 1; d4 = 4'hA; l4 = 0;
    step();
    d4 = 4'h9; l4 = 1;
    step();
    chk("eac_sum", 32'(if_a.sum), 32'h4);
    chk("eac_cks", 32'(if_a.checksum), 32'hB);
    chk("eac_norm_sum", 32'(if_an.sum), 32'h4);
    v4 = 0;
    step();

    // ---- negative zero {F, 0 last}
    v4 = 1; d4 = 4'hF; l4 = 0;
    step();
    d4 = 4'h0; l4 = 1;
    step();
    chk("nz_raw_sum", 32'(if_a.sum), 32'hF);
    chk("nz_raw_cks", 32'(if_a.checksum), 32'h0);
    chk("nz_norm_sum", 32'(if_an.sum), 32'h0);
    chk("nz_norm_cks", 32'(if_an.checksum), 32'hF);
    v4 = 0;
    step();

    // ---- backpressure: {1, 2 last} held 5 cycles, new frame offered meanwhile
    or4 = 0;
    v4 = 1; d4 = 4'h1; l4 = 0;
    step();
    d4 = 4'h2; l4 = 1;
    step();
    d4 = 4'h7; l4 = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovalid", 32'(if_a.out_valid), 32'h1);
      chk("bp_sum", 32'(if_a.sum), 32'h3);
      chk("bp_cks", 32'(if_a.checksum), 32'hC);
      chk("bp_wc", 32'(if_a.word_count), 32'h2);
      chk("bp_iready", 32'(if_a.in_ready), 32'h0);
      step();
    end
    or4 = 1;
    step();
    chk("bp_hs_ovalid", 32'(if_a.out_valid), 32'h0);
    chk("bp_hs_wc", 32'(if_a.word_count), 32'h0);
    chk("bp_hs_iready", 32'(if_a.in_ready), 32'h1);
    step();
    chk("bp_next_ovalid", 32'(if_a.out_valid), 32'h1);
    chk("bp_next_sum", 32'(if_a.sum), 32'h7);
    chk("bp_next_wc", 32'(if_a.word_count), 32'h1);
    v4 = 0;
    step();

    // ---- 16-bit IPv4 header
    v16 = 1;
    for (int i = 0; i < 9; i++) begin
      d16 = ip_words[i];
      l16 = (i == 8);
      if (i > 0) chk("ip_busy", 32'(if_b.busy), 32'h1);
      else       chk("ip_busy_first", 32'(if_b.busy), 32'h0);
      step();
    end
    v16 = 0;
    chk("ip_ovalid", 32'(if_b.out_valid), 32'h1);
    chk("ip_busy_done", 32'(if_b.busy), 32'h0);
    chk("ip_sum", 32'(if_b.sum), 32'h479E);
    chk("ip_cks", 32'(if_b.checksum), 32'hB861);
    chk("ip_wc", 32'(if_b.word_count), 32'h9);
    chk("ip_wc_sat", 32'(if_bc.word_count), 32'h3);
    step();

    // ---- 5-word frame on the 2-bit counter
    v16 = 1;
    for (int i = 1; i <= 5; i++) begin
      d16 = 16'(i);
      l16 = (i == 5);
      step();
    end
    v16 = 0;
    chk("w5_sum", 32'(if_bc.sum), 32'hF);
    chk("w5_wc_sat", 32'(if_bc.word_count), 32'h3);
    chk("w5_wc", 32'(if_b.word_count), 32'h5);
    step();

    // ---- clear on 3rd word of a 5-word frame
    v16 = 1; l16 = 0;
    d16 = 16'h0001; step();
    d16 = 16'h0002; step();
    d16 = 16'h0003; clr16 = 1; step();
    clr16 = 0; v16 = 0;
    chk("clr_busy", 32'(if_b.busy), 32'h0);
    chk("clr_ovalid", 32'(if_b.out_valid), 32'h0);
    chk("clr_wc", 32'(if_b.word_count), 32'h0);
    chk("clr_sum", 32'(if_b.sum), 32'h0);
    step();
    chk("clr_no_ov", 32'(if_b.out_valid), 32'h0);
    v16 = 1; d16 = 16'h1234; l16 = 1;
    step();
    v16 = 0;
    chk("post_clr_ovalid", 32'(if_b.out_valid), 32'h1);
    chk("post_clr_sum", 32'(if_b.sum), 32'h1234);
    chk("post_clr_wc", 32'(if_b.word_count), 32'h1);
    // clear beats a simultaneous result handshake
    clr16 = 1;
    step();
    clr16 = 0;
    chk("clr_hs_ovalid", 32'(if_b.out_valid), 32'h0);

    // ---- async reset mid-frame
    v16 = 1; l16 = 0;
    d16 = 16'h1111; step();
    d16 = 16'h2222; step();
    v16 = 0;
    chk("pre_rst_busy", 32'(if_b.busy), 32'h1);
    chk("pre_rst_sum", 32'(if_b.sum), 32'h3333);
    #2 rst = 1'b1;
    #1;
    chk_rst_values();
    #1 rst = 1'b0;

    // ---- async reset while in DONE
    v16 = 1; d16 = 16'h0F0F; l16 = 1; or16 = 0;
    step();
    v16 = 0;
    chk("pre_rst2_ovalid", 32'(if_b.out_valid), 32'h1);
    chk("pre_rst2_sum", 32'(if_b.sum), 32'h0F0F);
    #2 rst = 1'b1;
    #1;
    chk_rst_values();
    #1 rst = 1'b0;
    or16 = 1;
    step();
    chk("post_rst2_ovalid", 32'(if_b.out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
